// File: rtl/rd_fifo_burst_ctrl.sv
// ---------------------------------------------------------------------------
// rd_fifo_burst_ctrl
//
// Pulls bursts of data out of a read-side FIFO and presents them as a
// valid/ready stream. A burst is either a full BURST_LEN burst (when the FIFO
// holds at least that much) or, on flush_req, a partial burst of whatever is
// currently in the FIFO. Reads are credit-limited so the 4-entry output
// buffer can never overflow, whatever the read latency or downstream stalls.
//
// Ports
//   rd_clk, rd_rst        sole clock; asynchronous active-high reset
//   enable                permit new bursts to start
//   flush_req             level request to drain a partial burst
//   fifo_rd_en            read strobe to the FIFO
//   fifo_rd_data          FIFO data, valid RD_LATENCY cycles after fifo_rd_en
//   fifo_empty            FIFO empty flag
//   fifo_water_level      FIFO occupancy (DEPTH_WIDTH+1 bits)
//   m_data/m_valid/m_ready/m_last   output stream
//   burst_start           one-cycle pulse in the first cycle of a burst
//   burst_len             beats in the current burst
//   busy                  a burst is being issued or drained
// ---------------------------------------------------------------------------
module rd_fifo_burst_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WIDTH = 10,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    input  logic                  flush_req,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [DEPTH_WIDTH:0]  fifo_water_level,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  burst_start,
    output logic [8:0]            burst_len,
    output logic                  busy
);

    localparam logic [8:0] FullLen  = 9'(BURST_LEN);
    localparam int unsigned BufDepth = 4;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e state_q, state_d;

    logic [8:0] burst_len_q, burst_len_d;
    logic       burst_start_q, burst_start_d;
    logic [8:0] issued_q, issued_d;
    // Beats captured into the output buffer in the current burst; used to tag
    // the final beat with m_last as it is written.
    logic [8:0] captured_q, captured_d;

    // One bit per outstanding read, shifted along until its data returns.
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;

    logic [DATA_WIDTH-1:0] buf_data_q [BufDepth];
    logic [BufDepth-1:0]   buf_last_q;
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [2:0]            count_q, count_d;

    logic [31:0] level32;
    logic        full_ok, flush_ok;
    logic [3:0]  inflight;
    logic        rd_en;
    logic        push, pop, push_last;

    assign level32  = 32'(fifo_water_level);
    assign full_ok  = enable && (level32 >= BURST_LEN);
    assign flush_ok = enable && flush_req && (level32 != 32'd0) && (level32 < BURST_LEN);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight = inflight + 4'(pipe_q[i]);
        end
    end

    // Credit rule: reads in flight plus buffered beats stay below the buffer
    // depth before issuing, so every returning beat is guaranteed a slot.
    assign rd_en = (state_q == StIssue) && !fifo_empty && (issued_q < burst_len_q) &&
                   ((4'(count_q) + inflight) < 4'(BufDepth));

    assign push      = pipe_q[RD_LATENCY-1];
    assign pop       = m_valid && m_ready;
    assign push_last = (captured_q == (burst_len_q - 9'd1));

    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = rd_en;
    end

    assign count_d = count_q + 3'(push) - 3'(pop);

    // Next-state logic.
    always_comb begin
        state_d       = state_q;
        burst_len_d   = burst_len_q;
        burst_start_d = 1'b0;
        issued_d      = issued_q;
        captured_d    = captured_q + 9'(push);

        unique case (state_q)
            StIdle: begin
                // A full burst wins over a flush when both qualify.
                if (full_ok) begin
                    burst_len_d   = FullLen;
                    burst_start_d = 1'b1;
                    issued_d      = '0;
                    captured_d    = '0;
                    state_d       = StIssue;
                end else if (flush_ok) begin
                    burst_len_d   = 9'(level32);
                    burst_start_d = 1'b1;
                    issued_d      = '0;
                    captured_d    = '0;
                    state_d       = StIssue;
                end
            end
            StIssue: begin
                if (rd_en) begin
                    issued_d = issued_q + 9'd1;
                    if (issued_q == (burst_len_q - 9'd1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Returning to idle here forces at least one idle cycle
                // before the next burst decision.
                if (pop && m_last && (inflight == 4'd0)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q       <= StIdle;
            burst_len_q   <= '0;
            burst_start_q <= 1'b0;
            issued_q      <= '0;
            captured_q    <= '0;
            pipe_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            buf_last_q    <= '0;
            for (int i = 0; i < int'(BufDepth); i++) begin
                buf_data_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            burst_len_q   <= burst_len_d;
            burst_start_q <= burst_start_d;
            issued_q      <= issued_d;
            captured_q    <= captured_d;
            pipe_q        <= pipe_d;
            count_q       <= count_d;
            if (push) begin
                buf_data_q[wr_ptr_q] <= fifo_rd_data;
                buf_last_q[wr_ptr_q] <= push_last;
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
        end
    end

    assign fifo_rd_en  = rd_en;
    assign m_valid     = (count_q != 3'd0);
    assign m_data      = buf_data_q[rd_ptr_q];
    assign m_last      = m_valid && buf_last_q[rd_ptr_q];
    assign burst_start = burst_start_q;
    assign burst_len   = burst_len_q;
    assign busy        = (state_q != StIdle);

`ifndef SYNTHESIS
    // The issue credit check must make buffer overflow unreachable.
    assert property (@(posedge rd_clk) disable iff (rd_rst)
                     !(push && !pop && (count_q == 3'(BufDepth))));
    assert property (@(posedge rd_clk) disable iff (rd_rst) !(fifo_rd_en && fifo_empty));
`endif

endmodule

// File: tb/tb_rd_fifo_burst_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for rd_fifo_burst_ctrl. Two instances run side by side from the same
// control inputs: one with RD_LATENCY=1 and one with RD_LATENCY=2. Each has
// its own FIFO model. Expected burst lengths, beat order and m_last positions
// come from the burst rules applied to the FIFO contents.
// ---------------------------------------------------------------------------
module tb_rd_fifo_burst_ctrl;

    localparam int DW   = 32;
    localparam int DEPW = 10;
    localparam int BL   = 16;
    localparam int NI   = 2;
    localparam int MEM  = 1024;

    typedef logic [DEPW:0] lvl_t;

    logic rd_clk = 1'b0;
    logic rd_rst;
    always #5 rd_clk = ~rd_clk;

    logic [NI-1:0]          enable;
    logic                   flush_req;
    logic                   m_ready;
    logic [NI-1:0]          fifo_rd_en;
    logic [NI-1:0][DW-1:0]  fifo_rd_data;
    logic [NI-1:0]          fifo_empty;
    logic [NI-1:0][DEPW:0]  level;
    logic [NI-1:0][DW-1:0]  m_data;
    logic [NI-1:0]          m_valid, m_last, burst_start, busy;
    logic [NI-1:0][8:0]     burst_len;

    rd_fifo_burst_ctrl #(.DATA_WIDTH(DW), .DEPTH_WIDTH(DEPW), .BURST_LEN(BL), .RD_LATENCY(1))
    u_dut_l1 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable[0]), .flush_req(flush_req),
        .fifo_rd_en(fifo_rd_en[0]), .fifo_rd_data(fifo_rd_data[0]), .fifo_empty(fifo_empty[0]),
        .fifo_water_level(level[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready), .m_last(m_last[0]), .burst_start(burst_start[0]),
        .burst_len(burst_len[0]), .busy(busy[0])
    );

    rd_fifo_burst_ctrl #(.DATA_WIDTH(DW), .DEPTH_WIDTH(DEPW), .BURST_LEN(BL), .RD_LATENCY(2))
    u_dut_l2 (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable[1]), .flush_req(flush_req),
        .fifo_rd_en(fifo_rd_en[1]), .fifo_rd_data(fifo_rd_data[1]), .fifo_empty(fifo_empty[1]),
        .fifo_water_level(level[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready), .m_last(m_last[1]), .burst_start(burst_start[1]),
        .burst_len(burst_len[1]), .busy(busy[1])
    );

    // FIFO model: a word array with write/read counters and a latency pipe.
    logic [DW-1:0]         src_data [NI][MEM];
    int                    src_wr [NI];
    int                    src_rd [NI];
    logic [NI-1:0][DW-1:0] d1, d2;
    bit                    empty_toggle;
    bit                    phase;

    // Observations.
    int            got_n [NI];
    logic [DW-1:0] got_data [NI][64];
    bit            got_last [NI][64];
    int            nstart [NI];
    int            start_len [NI][8];
    int            nrd [NI];
    int            empty_viol [NI];
    int            gap_viol [NI];
    int            max_out [NI];
    int            first_rd [NI], last_rd [NI], first_acc [NI], last_acc [NI];
    bit            prev_busy [NI];
    int            base [NI];
    int            cyc;

    int tests;
    int fails;

    task automatic drive_src();
        for (int k = 0; k < NI; k++) begin
            fifo_rd_data[k] = (k == 0) ? d1[k] : d2[k];
            fifo_empty[k]   = (src_wr[k] == src_rd[k]) || (empty_toggle && phase);
            level[k]        = lvl_t'(src_wr[k] - src_rd[k]);
        end
    endtask

    // Make the FIFO hold exactly n fresh random words (only while idle).
    task automatic set_avail(input int n);
        for (int k = 0; k < NI; k++) begin
            src_rd[k] = src_wr[k];
            for (int i = 0; i < n; i++) begin
                src_data[k][src_wr[k] % MEM] = $urandom;
                src_wr[k]++;
            end
        end
        drive_src();
    endtask

    task automatic clear_records();
        for (int k = 0; k < NI; k++) begin
            got_n[k] = 0; nstart[k] = 0; nrd[k] = 0; empty_viol[k] = 0; gap_viol[k] = 0;
            max_out[k] = 0; first_rd[k] = 0; last_rd[k] = 0; first_acc[k] = 0;
            last_acc[k] = 0; prev_busy[k] = busy[k]; base[k] = src_rd[k];
            for (int i = 0; i < 8; i++) start_len[k][i] = 0;
        end
    endtask

    // One clock: observe at the falling edge, update the FIFO model after the
    // rising edge.
    task automatic step();
        bit fire [NI];
        @(negedge rd_clk);
        for (int k = 0; k < NI; k++) begin
            fire[k] = fifo_rd_en[k] && !fifo_empty[k];
            if (fifo_rd_en[k] && fifo_empty[k]) empty_viol[k]++;
            if (fifo_rd_en[k]) begin
                if (nrd[k] == 0) first_rd[k] = cyc;
                last_rd[k] = cyc;
                nrd[k]++;
            end
            if (nrd[k] - got_n[k] > max_out[k]) max_out[k] = nrd[k] - got_n[k];
            if (burst_start[k]) begin
                if (prev_busy[k]) gap_viol[k]++;
                if (nstart[k] < 8) start_len[k][nstart[k]] = int'(burst_len[k]);
                nstart[k]++;
            end
            prev_busy[k] = busy[k];
            if (m_valid[k] && m_ready) begin
                if (got_n[k] < 64) begin
                    got_data[k][got_n[k]] = m_data[k];
                    got_last[k][got_n[k]] = m_last[k];
                end
                if (got_n[k] == 0) first_acc[k] = cyc;
                last_acc[k] = cyc;
                got_n[k]++;
            end
        end
        @(posedge rd_clk);
        #1;
        cyc++;
        phase = ~phase;
        for (int k = 0; k < NI; k++) begin
            d2[k] = d1[k];
            if (fire[k]) begin
                d1[k] = src_data[k][src_rd[k] % MEM];
                src_rd[k]++;
            end else begin
                d1[k] = $urandom;  // junk outside the valid data window
            end
        end
        drive_src();
    endtask

    // ready_mode: 0 always ready, 1 ready low for 20 cycles mid-burst, 2 random.
    task automatic run(input string name, input int nb, input int ready_mode, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            for (int k = 0; k < NI; k++) enable[k] = (nstart[k] < nb);
            case (ready_mode)
                1:       m_ready = !(c >= 6 && c < 26);
                2:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b1;
            endcase
            step();
            done = 1'b1;
            for (int k = 0; k < NI; k++) if (nstart[k] < nb || busy[k]) done = 1'b0;
        end
        enable  = '0;
        m_ready = 1'b1;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s completion: bursts not finished within %0d cycles", name, budget);
        end
    endtask

    // Compare observations against the burst rules applied to a FIFO that
    // starts with a0 words.
    task automatic check(input string name, input int a0, input bit fl, input int nb);
        int lens [4];
        int a, tot, j, bad_d, bad_l;
        a = a0; tot = 0;
        for (int i = 0; i < 4; i++) begin
            lens[i] = (a >= BL) ? BL : ((fl && a > 0) ? a : 0);
            if (i >= nb) lens[i] = 0;
            a -= lens[i];
            tot += lens[i];
        end
        for (int k = 0; k < NI; k++) begin
            tests++;
            if (nstart[k] != nb) begin
                fails++;
                $display("FAIL %s[%0d] burst_start count: got %0d want %0d", name, k, nstart[k], nb);
            end
            for (int i = 0; i < nb; i++) begin
                tests++;
                if (start_len[k][i] != lens[i]) begin
                    fails++;
                    $display("FAIL %s[%0d] burst_len #%0d: got %0d want %0d", name, k, i,
                             start_len[k][i], lens[i]);
                end
            end
            tests++;
            if (nrd[k] != tot) begin
                fails++;
                $display("FAIL %s[%0d] read count: got %0d want %0d", name, k, nrd[k], tot);
            end
            tests++;
            if (got_n[k] != tot) begin
                fails++;
                $display("FAIL %s[%0d] beat count: got %0d want %0d", name, k, got_n[k], tot);
            end
            j = 0; bad_d = 0; bad_l = 0;
            for (int b = 0; b < nb; b++) begin
                for (int o = 0; o < lens[b]; o++) begin
                    if (j < got_n[k] && j < 64) begin
                        if (got_data[k][j] !== src_data[k][(base[k] + j) % MEM]) bad_d++;
                        if (got_last[k][j] !== (o == lens[b] - 1)) bad_l++;
                    end
                    j++;
                end
            end
            tests++;
            if (bad_d != 0) begin
                fails++;
                $display("FAIL %s[%0d] beat data order: %0d wrong beats, want 0", name, k, bad_d);
            end
            tests++;
            if (bad_l != 0) begin
                fails++;
                $display("FAIL %s[%0d] m_last placement: %0d wrong beats, want 0", name, k, bad_l);
            end
            tests++;
            if (empty_viol[k] != 0 || gap_viol[k] != 0) begin
                fails++;
                $display("FAIL %s[%0d] protocol: reads-while-empty %0d, back-to-back starts %0d, want 0",
                         name, k, empty_viol[k], gap_viol[k]);
            end
            tests++;
            if (max_out[k] > 4) begin
                fails++;
                $display("FAIL %s[%0d] outstanding beats: got %0d want <= 4", name, k, max_out[k]);
            end
            tests++;
            if (busy[k] !== 1'b0) begin
                fails++;
                $display("FAIL %s[%0d] busy after burst: got %b want 0", name, k, busy[k]);
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        for (int k = 0; k < NI; k++) begin
            tests++;
            if ({fifo_rd_en[k], m_valid[k], m_last[k], burst_start[k], busy[k], burst_len[k],
                 m_data[k]} !== '0) begin
                fails++;
                $display("FAIL %s[%0d] outputs in reset: rd_en %b valid %b last %b start %b busy %b len %0d data %h, want all 0",
                         name, k, fifo_rd_en[k], m_valid[k], m_last[k], burst_start[k], busy[k],
                         burst_len[k], m_data[k]);
            end
        end
    endtask

    task automatic test_reset();
        rd_rst = 1'b1;
        repeat (3) @(posedge rd_clk);
        #1;
        check_outputs_zero("reset");
        rd_rst = 1'b0;
    endtask

    task automatic test_full_burst();
        set_avail(20); flush_req = 1'b0; clear_records();
        run("full", 1, 0, 80);
        check("full", 20, 1'b0, 1);
        for (int k = 0; k < NI; k++) begin
            tests++;
            if (last_rd[k] - first_rd[k] != BL - 1 || last_acc[k] - first_acc[k] != BL - 1) begin
                fails++;
                $display("FAIL full[%0d] throughput: read span %0d beat span %0d, want %0d",
                         k, last_rd[k] - first_rd[k], last_acc[k] - first_acc[k], BL - 1);
            end
        end
    endtask

    task automatic test_flush();
        set_avail(5); flush_req = 1'b1; clear_records();
        run("flush5", 1, 0, 60);
        check("flush5", 5, 1'b1, 1);
        // Empty FIFO with flush requested must not start anything.
        set_avail(0); clear_records();
        enable = '1;
        repeat (8) step();
        enable = '0;
        for (int k = 0; k < NI; k++) begin
            tests++;
            if (nstart[k] != 0 || nrd[k] != 0 || busy[k] !== 1'b0) begin
                fails++;
                $display("FAIL flush0[%0d] idle on empty: starts %0d reads %0d busy %b, want 0/0/0",
                         k, nstart[k], nrd[k], busy[k]);
            end
        end
        flush_req = 1'b0;
    endtask

    task automatic test_priority();
        // 20 words with flush: full burst first, then the 4-word remainder.
        set_avail(20); flush_req = 1'b1; clear_records();
        run("priority", 2, 0, 120);
        check("priority", 20, 1'b1, 2);
        flush_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        set_avail(40); flush_req = 1'b0; clear_records();
        run("b2b", 2, 0, 120);
        check("b2b", 40, 1'b0, 2);
    endtask

    task automatic test_stall();
        set_avail(20); flush_req = 1'b0; clear_records();
        run("stall", 1, 1, 120);
        check("stall", 20, 1'b0, 1);
        for (int k = 0; k < NI; k++) begin
            tests++;
            if (max_out[k] != 4) begin
                fails++;
                $display("FAIL stall[%0d] buffer fill under stall: got %0d want 4", k, max_out[k]);
            end
        end
    endtask

    task automatic test_empty_toggle();
        empty_toggle = 1'b1;
        set_avail(16); flush_req = 1'b0; clear_records();
        run("etoggle", 1, 0, 120);
        check("etoggle", 16, 1'b0, 1);
        empty_toggle = 1'b0;
        drive_src();
    endtask

    task automatic test_random();
        int a;
        for (int it = 0; it < 3; it++) begin
            a = $urandom_range(17, 31);
            empty_toggle = ($urandom_range(0, 1) == 1);
            set_avail(a); flush_req = 1'b1; clear_records();
            run("random", 2, 2, 400);
            check("random", a, 1'b1, 2);
        end
        empty_toggle = 1'b0;
        flush_req    = 1'b0;
        drive_src();
    endtask

    task automatic test_mid_reset();
        bit hit;
        set_avail(20); flush_req = 1'b0; clear_records();
        hit = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            enable = '1; m_ready = 1'b1;
            step();
            if (got_n[0] >= 7) hit = 1'b1;
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL midreset reaching beat 7: got %0d beats want 7", got_n[0]);
        end
        enable = '0;
        rd_rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(posedge rd_clk);
        #1;
        rd_rst = 1'b0;
        d1 = '0; d2 = '0;
        set_avail(20); clear_records();
        run("postreset", 1, 0, 80);
        check("postreset", 20, 1'b0, 1);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        rd_rst = 1'b1; enable = '0; flush_req = 1'b0; m_ready = 1'b1;
        empty_toggle = 1'b0; phase = 1'b0; d1 = '0; d2 = '0;
        for (int k = 0; k < NI; k++) begin
            src_wr[k] = 0; src_rd[k] = 0;
        end
        drive_src();

        test_reset();
        test_full_burst();
        test_flush();
        test_priority();
        test_back_to_back();
        test_stall();
        test_empty_toggle();
        test_random();
        test_mid_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rd_fifo_burst_ctrl.md
RD_FIFO_BURST_CTRL -- requirements
Module: rd_fifo_burst_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning FIFO read-data and stream width.
REQ-002 SHALL have parameter DEPTH_WIDTH, default 10, meaning FIFO read-depth width; the water-level input is DEPTH_WIDTH+1 bits.
REQ-003 SHALL have parameter BURST_LEN, default 16, meaning beats per full burst (2..256).
REQ-004 SHALL have parameter RD_LATENCY, default 1, meaning fifo_rd_en-to-data cycles (1 = no output reg, 2 = output reg).
REQ-005 SHALL have ports rd_clk in 1 (sole clock); rd_rst in 1 (reset, asynchronous, active-high).
REQ-006 SHALL have ports enable in 1 (permit new bursts); flush_req in 1 (level-sensitive request to drain a partial burst).
REQ-007 SHALL have ports fifo_rd_en out 1; fifo_rd_data in DATA_WIDTH; fifo_empty in 1; fifo_water_level in DEPTH_WIDTH+1.
REQ-008 SHALL have ports m_data out DATA_WIDTH; m_valid out 1; m_ready in 1; m_last out 1.
REQ-009 SHALL have ports burst_start out 1 (one-cycle pulse); burst_len out 9 (beats in the current burst); busy out 1.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, DRAIN.
REQ-011 In IDLE with enable=1 and fifo_water_level >= BURST_LEN, the FSM SHALL latch burst_len=BURST_LEN, pulse burst_start and go to ISSUE next cycle.
REQ-012 In IDLE with enable=1, flush_req=1, 0 < level < BURST_LEN, the FSM SHALL latch burst_len=level and start the burst identically; level=0 SHALL start nothing.
REQ-013 A full burst SHALL take priority over a flush when both qualify.
REQ-014 In ISSUE, fifo_rd_en SHALL assert only when fifo_empty=0, issued < burst_len and (in-flight + buffer occupancy) < 4.
REQ-015 When the burst_len-th read has been issued, the FSM SHALL go to DRAIN.
REQ-016 In DRAIN, once all in-flight data has arrived and the last beat has been accepted (m_valid & m_ready & m_last), the FSM SHALL return to IDLE.
REQ-017 Read data SHALL be captured exactly RD_LATENCY cycles after each fifo_rd_en into a 4-entry output FIFO; no capture SHALL be dropped or duplicated.
REQ-018 m_valid SHALL be high iff the output buffer is non-empty; m_data/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-019 m_last SHALL be 1 only on the beat whose burst index equals burst_len-1.
REQ-020 busy SHALL be 1 in ISSUE and DRAIN and 0 in IDLE.
REQ-021 The issue counter SHALL be 9 bits and SHALL reset to 0 at each burst_start; no wrap is permitted within a burst.
REQ-022 Deasserting enable or flush_req mid-burst SHALL NOT abort the burst; it affects only the next IDLE decision.
REQ-023 Throughput SHALL be one beat per cycle when m_ready=1 continuously and the FIFO is non-empty.
REQ-024 A new burst SHALL NOT start in the same cycle as the previous burst's final acceptance; minimum one IDLE cycle between bursts.

Reset
REQ-025 On rd_rst=1, asynchronously: FSM=IDLE; fifo_rd_en, m_valid, m_last, burst_start, busy = 0; burst_len, counters, buffer pointers = 0; m_data = 0.
REQ-026 rd_rst asserted mid-burst SHALL discard buffered and in-flight data; after release, behaviour SHALL match power-up.

Verification
REQ-027 BURST_LEN=16, level=20, enable=1, m_ready=1 -> burst_start pulse, burst_len=16, 16 consecutive fifo_rd_en, 16 beats with m_last on beat 15, busy falls after.
REQ-028 level=5, flush_req=1, enable=1 -> burst_len=5, exactly 5 reads, m_last on beat 4; level=0 with flush_req -> no burst_start.
REQ-029 m_ready=0 for 20 cycles mid-burst -> at most 4 beats outstanding in buffer, fifo_rd_en stalls, no data lost; resumes in order.
REQ-030 RD_LATENCY=2, fifo_empty toggling every other cycle -> fifo_rd_en never asserted while empty, beat sequence equals FIFO order.
REQ-031 rd_rst pulsed at beat 7 of 16 -> all outputs 0 within the reset, next burst starts clean with m_last at beat 15.
